fetch_pair_queue: RTL and testbench
===================================

FETCH_PAIR_QUEUE -- requirements
Module: fetch_pair_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction-pair entries (power of two, at least 2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded at reset.
REQ-003 Parameter NOP_INST, default 32'h0000_0013, filler instruction for a misaligned redirect slot.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_req  output  1  fetch request for address imem_addr this cycle.
REQ-007 imem_addr  output  32  8-byte-aligned fetch address.
REQ-008 imem_rdata  input  64  {second inst, first inst}, valid exactly one cycle after imem_req.
REQ-009 redirect_valid  input  1  flush and restart fetch.
REQ-010 redirect_pc  input  32  restart address, 4-byte aligned.
REQ-011 dec_valid  output  1  instA/instB/pc hold a valid pair for the decoder.
REQ-012 dec_ready  input  1  decoder accepts the pair this cycle.
REQ-013 instA  output  32  first (older) instruction of the pair.
REQ-014 instB  output  32  second instruction of the pair.
REQ-015 pc  output  32  address of instA's 8-byte-aligned pair.

Function
REQ-016 The block SHALL hold an internal fetch_pc, drive imem_addr = fetch_pc, and add 8 to fetch_pc on every cycle imem_req is high.
REQ-017 The block SHALL assert imem_req only when count + inflight < DEPTH, where inflight (0 or 1) is the request issued the previous cycle.
REQ-018 The block SHALL write {imem_rdata[63:32], imem_rdata[31:0], request address} into the tail entry one cycle after each non-discarded request.
REQ-019 The block SHALL drive dec_valid = (count != 0) and present the head entry on instA/instB/pc with zero added latency, combinationally from storage.
REQ-020 The block SHALL pop the head on a cycle where dec_valid && dec_ready, and SHALL hold the outputs stable while dec_valid && !dec_ready.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance, wrapping modulo DEPTH.
REQ-022 The push path SHALL never see a full queue, because REQ-017 reserves the slot; an overflow SHALL be an assertion failure.
REQ-023 On redirect_valid the block SHALL, in that cycle, clear count and pointers, mark any inflight response for discard, set fetch_pc = {redirect_pc[31:3], 3'b000}, and deassert imem_req.
REQ-024 redirect_valid SHALL take priority over a push or pop in the same cycle, and a pop handshake in that cycle SHALL have no effect on queue state.
REQ-025 If redirect_pc[2] = 1, the first pair written after the redirect SHALL have instA = NOP_INST, with instB taken from the fetched data.
REQ-026 dec_valid SHALL be 0 in the cycle after a redirect; the first post-redirect pair SHALL appear no earlier than 2 cycles after the redirect cycle.
REQ-027 fetch_pc SHALL wrap from 32'hFFFF_FFF8 to 0 with no special handling.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL set fetch_pc = RESET_PC, count = 0, pointers = 0, inflight = 0, and the discard flag = 0.
REQ-029 Output reset values SHALL be: imem_req = 0 and dec_valid = 0, with instA, instB and pc all 0 whenever dec_valid = 0.
REQ-030 A reset asserted mid-operation SHALL drop any inflight response, and imem_req SHALL rise no earlier than the first cycle after rst falls.

Structure
REQ-031 A shared core package SHALL hold INST_W = 32, PAIR_W = 64, NOP_INST and the entry layout {pc, instB, instA} (96 bits).
REQ-032 Storage SHALL be one sub-module, pair_fifo_mem (DEPTH x 96, 1 write port, asynchronous read); fetch_pc, the counters and redirect control SHALL stay in fetch_pair_queue.

Verification
REQ-033 Reset followed by dec_ready = 1 with no redirects -> pairs appear at pc = 0, 8, 16, ..., the first with dec_valid in the 2nd cycle after rst falls, then one pair per cycle.
REQ-034 dec_ready held at 0 -> exactly DEPTH = 4 requests issued, imem_req then stays 0, the outputs stay stable at pc = 0; releasing dec_ready -> pairs 0, 8, 16, 24 drain in order.
REQ-035 redirect_pc = 32'h0000_0104 while the queue is full and a request is inflight -> the next dec_valid pair has pc = 32'h100, instA = 32'h0000_0013, instB = mem[0x104]; no stale pair appears.
REQ-036 redirect_valid and a dec_valid && dec_ready handshake in the same cycle -> queue is empty afterwards, and dec_valid = 0 in the following cycle.
REQ-037 rst pulsed for one cycle mid-stream -> the response to the last request is discarded, and fetch restarts at RESET_PC.
REQ-038 Random dec_ready pattern over 1000 cycles -> the decoder sees a gap-free, in-order pc sequence, count never exceeds DEPTH, and the overflow assertion never fires.

Source files
------------

// File: rtl/fetch_pair_queue_pkg.sv
// Shared widths, default filler instruction and queue entry layout for the
// instruction-pair fetch queue.
package fetch_pair_queue_pkg;

    localparam int INST_W = 32;
    localparam int PAIR_W = 64;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst_b;
        logic [INST_W-1:0] inst_a;
    } pair_entry_t;

    localparam int ENTRY_W = $bits(pair_entry_t);

endpackage

// File: rtl/fetch_pair_queue_if.sv
// Instruction-memory, redirect and decoder signals of the fetch pair queue.
// master = the queue itself, slave = memory/decoder environment.
interface fetch_pair_queue_if;
    import fetch_pair_queue_pkg::*;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic [PAIR_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [INST_W-1:0] instA;
    logic [INST_W-1:0] instB;
    logic [31:0]       pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output dec_valid,
        input  dec_ready,
        output instA, instB, pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  instA, instB, pc
    );

endinterface

// File: rtl/fetch_pair_queue_mem.sv
// Pair storage: DEPTH entries, one synchronous write port, asynchronous read
// so the head entry reaches the decoder with no added latency.
module pair_fifo_mem
    import fetch_pair_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  pair_entry_t      wdata,
    input  logic [PTR_W-1:0] raddr,
    output pair_entry_t      rdata
);

    pair_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_pair_queue.sv
// Fetches 8-byte instruction pairs ahead of the decoder, queues them, and
// flushes/restarts on redirect.
module fetch_pair_queue
    import fetch_pair_queue_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [31:0]       RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP_INST = fetch_pair_queue_pkg::NOP_INST
) (
    input logic                 clk,
    input logic                 rst,
    fetch_pair_queue_if.master  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_addr_q, inflight_addr_d;
    logic             inflight_nop_q, inflight_nop_d;
    logic             nop_pending_q, nop_pending_d;

    logic             req;
    logic             valid;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;
    pair_entry_t      wr_entry;
    pair_entry_t      rd_entry;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^bus.redirect_pc[1:0];

    // A slot is reserved for the inflight response, so push can never overflow.
    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign req       = !rst && !bus.redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
    assign valid     = (count_q != '0);
    // The response arriving during a redirect belongs to the old stream.
    assign push      = inflight_q && !bus.redirect_valid;
    assign pop       = valid && bus.dec_ready && !bus.redirect_valid;

    always_comb begin
        wr_entry.pc     = inflight_addr_q;
        wr_entry.inst_b = bus.imem_rdata[63:32];
        wr_entry.inst_a = inflight_nop_q ? NOP_INST : bus.imem_rdata[31:0];
    end

    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        count_d         = count_q;
        head_d          = head_q;
        tail_d          = tail_q;
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        inflight_nop_d  = inflight_nop_q;
        nop_pending_d   = nop_pending_q;

        if (bus.redirect_valid) begin
            fetch_pc_d    = {bus.redirect_pc[31:3], 3'b000};
            count_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            nop_pending_d = bus.redirect_pc[2];
        end else begin
            if (req) begin
                fetch_pc_d      = fetch_pc_q + 32'd8;
                inflight_d      = 1'b1;
                inflight_addr_d = fetch_pc_q;
                inflight_nop_d  = nop_pending_q;
                nop_pending_d   = 1'b0;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q      <= RESET_PC;
            count_q         <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            inflight_nop_q  <= 1'b0;
            nop_pending_q   <= 1'b0;
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            count_q         <= count_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            inflight_nop_q  <= inflight_nop_d;
            nop_pending_q   <= nop_pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count_q == CNT_W'(DEPTH)));
        end
    end

    pair_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.dec_valid = valid;
    assign bus.instA     = valid ? rd_entry.inst_a : '0;
    assign bus.instB     = valid ? rd_entry.inst_b : '0;
    assign bus.pc        = valid ? rd_entry.pc     : '0;

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed and random-backpressure bench for fetch_pair_queue with a
// one-cycle-latency instruction memory model.
module tb_fetch_pair_queue;
    import fetch_pair_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_pair_queue_if bus();

    fetch_pair_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory answers one cycle after a request; junk otherwise exposes stray pushes.
    always @(posedge clk) begin
        if (bus.imem_req)
            bus.imem_rdata <= {mem_word(bus.imem_addr + 32'd4), mem_word(bus.imem_addr)};
        else
            bus.imem_rdata <= 64'hBAD0_BAD1_BAD2_BAD3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.dec_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.dec_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %0b want 0", bus.imem_req); end
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %0b want 0", bus.dec_valid); end
        checks++; if (bus.instA !== 32'h0) begin errors++; $display("FAIL reset_instA: got %h want 0", bus.instA); end
        checks++; if (bus.instB !== 32'h0) begin errors++; $display("FAIL reset_instB: got %h want 0", bus.instB); end
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.pc); end
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got req=%0b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        tick();
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_latency1: got dec_valid=%0b want 0", bus.dec_valid); end
        tick();
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h0 || bus.instA !== mem_word(32'h0) || bus.instB !== mem_word(32'h4)) begin
            errors++; $display("FAIL reset_first_pair: got v=%0b pc=%h a=%h b=%h want v=1 pc=0 a=%h b=%h", bus.dec_valid, bus.pc, bus.instA, bus.instB, mem_word(32'h0), mem_word(32'h4));
        end
        $display("test_reset: first pair pc=%h", bus.pc);
    endtask

    task automatic test_stream();
        do_reset();
        bus.dec_ready = 1'b1;
        tick();
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got dec_valid=%0b want 0", bus.dec_valid); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp_pc;
            tick();
            exp_pc = 32'(i * 8);
            checks++;
            if (bus.dec_valid !== 1'b1 || bus.pc !== exp_pc || bus.instA !== mem_word(exp_pc) || bus.instB !== mem_word(exp_pc + 32'd4)) begin
                errors++; $display("FAIL stream_pair%0d: got v=%0b pc=%h a=%h b=%h want pc=%h", i, bus.dec_valid, bus.pc, bus.instA, bus.instB, exp_pc);
            end
            $display("stream: pair pc=%h instA=%h instB=%h", bus.pc, bus.instA, bus.instB);
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        int unstable = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req === 1'b1) nreq++;
            if (bus.dec_valid === 1'b1 && bus.pc !== 32'h0) unstable++;
            tick();
        end
        checks++; if (nreq != DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d want %0d", nreq, DEPTH); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stopped: got %0b want 0", bus.imem_req); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h0 || bus.instA !== mem_word(32'h0)) begin
            errors++; $display("FAIL bp_hold: got v=%0b pc=%h a=%h want v=1 pc=0 a=%h", bus.dec_valid, bus.pc, bus.instA, mem_word(32'h0));
        end
        bus.dec_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(k * 8);
            checks++;
            if (bus.dec_valid !== 1'b1 || bus.pc !== exp_pc || bus.instB !== mem_word(exp_pc + 32'd4)) begin
                errors++; $display("FAIL bp_drain%0d: got v=%0b pc=%h b=%h want pc=%h", k, bus.dec_valid, bus.pc, bus.instB, exp_pc);
            end
            $display("drain: pair pc=%h", bus.pc);
            tick();
        end
    endtask

    task automatic test_redirect_misaligned();
        do_reset();
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0104;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_low: got %0b want 0", bus.imem_req); end
        tick();
        bus.redirect_valid = 1'b0;
        bus.dec_ready = 1'b1;
        #1;
        checks++; if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
            errors++; $display("FAIL redir_restart: got v=%0b req=%0b addr=%h want v=0 req=1 addr=100", bus.dec_valid, bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL redir_no_stale: got dec_valid=%0b pc=%h want 0", bus.dec_valid, bus.pc); end
        tick();
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h100 || bus.instA !== 32'h0000_0013 || bus.instB !== mem_word(32'h104)) begin
            errors++; $display("FAIL redir_nop_pair: got v=%0b pc=%h a=%h b=%h want pc=100 a=00000013 b=%h", bus.dec_valid, bus.pc, bus.instA, bus.instB, mem_word(32'h104));
        end
        $display("redirect: pair pc=%h instA=%h instB=%h", bus.pc, bus.instA, bus.instB);
        tick();
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h108 || bus.instA !== mem_word(32'h108)) begin
            errors++; $display("FAIL redir_second_pair: got v=%0b pc=%h a=%h want pc=108 a=%h", bus.dec_valid, bus.pc, bus.instA, mem_word(32'h108));
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        bus.dec_ready = 1'b1;
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        #1;
        checks++; if (bus.dec_valid !== 1'b1) begin errors++; $display("FAIL rp_handshake: got dec_valid=%0b want 1", bus.dec_valid); end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++; if (bus.dec_valid !== 1'b0 || bus.pc !== 32'h0) begin errors++; $display("FAIL rp_empty: got v=%0b pc=%h want v=0 pc=0", bus.dec_valid, bus.pc); end
        tick();
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL rp_still_empty: got %0b want 0", bus.dec_valid); end
        tick();
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h200 || bus.instA !== mem_word(32'h200)) begin
            errors++; $display("FAIL rp_restart: got v=%0b pc=%h a=%h want pc=200 a=%h", bus.dec_valid, bus.pc, bus.instA, mem_word(32'h200));
        end
        $display("redirect_pop: pair pc=%h", bus.pc);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.dec_ready = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_in_reset: got %0b want 0", bus.imem_req); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.dec_valid !== 1'b0) begin
            errors++; $display("FAIL mid_restart: got req=%0b addr=%h v=%0b want req=1 addr=0 v=0", bus.imem_req, bus.imem_addr, bus.dec_valid);
        end
        tick();
        checks++; if (bus.dec_valid !== 1'b0) begin errors++; $display("FAIL mid_discard: got v=%0b pc=%h want v=0", bus.dec_valid, bus.pc); end
        tick();
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h0 || bus.instA !== mem_word(32'h0)) begin
            errors++; $display("FAIL mid_first_pair: got v=%0b pc=%h a=%h want pc=0 a=%h", bus.dec_valid, bus.pc, bus.instA, mem_word(32'h0));
        end
        $display("reset_mid: pair pc=%h", bus.pc);
    endtask

    task automatic test_wrap();
        do_reset();
        bus.dec_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        #1;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        for (int i = 0; i < 10 && bus.dec_valid !== 1'b1; i++) tick();
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'hFFFF_FFF8 || bus.instB !== mem_word(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_top: got v=%0b pc=%h b=%h want pc=fffffff8 b=%h", bus.dec_valid, bus.pc, bus.instB, mem_word(32'hFFFF_FFFC));
        end
        tick();
        checks++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h0 || bus.instA !== mem_word(32'h0)) begin
            errors++; $display("FAIL wrap_zero: got v=%0b pc=%h a=%h want pc=0 a=%h", bus.dec_valid, bus.pc, bus.instA, mem_word(32'h0));
        end
        $display("wrap: pair pc=%h", bus.pc);
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        int reqs = 0;
        int pops = 0;
        int over = 0;
        do_reset();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            bus.dec_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.imem_req === 1'b1) reqs++;
            if (bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
                checks++;
                if (bus.pc !== exp_pc || bus.instA !== mem_word(exp_pc) || bus.instB !== mem_word(exp_pc + 32'd4)) begin
                    errors++; $display("FAIL rand_pair: got pc=%h a=%h b=%h want pc=%h", bus.pc, bus.instA, bus.instB, exp_pc);
                end
                exp_pc = exp_pc + 32'd8;
                pops++;
            end
            if (reqs - pops > DEPTH) over++;
            tick();
        end
        checks++; if (over != 0) begin errors++; $display("FAIL rand_occupancy: got %0d cycles over depth want 0", over); end
        checks++; if (pops < 100) begin errors++; $display("FAIL rand_progress: got %0d pops want >=100", pops); end
        $display("random: %0d pairs consumed, last expected pc=%h", pops, exp_pc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.dec_ready = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_misaligned();
        test_redirect_pop();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
